// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - pulse encoding constants shared by servo encoder and decoder
//
// Purpose: one place for the servo pulse encoding, so that servo_controller and
//          servo_pulse_decoder cannot drift apart.
//          High time = (position + OFFSET_UNITS) << STEP_SHIFT clk cycles,
//          frame period = 2**FRAME_LEN clk cycles.
// Ports:   none (package).
package servo_pkg;

    localparam int STEP_SHIFT   = 8;    // log2 of clk cycles per position step
    localparam int OFFSET_UNITS = 165;  // position-0 pulse width in steps
    localparam int FRAME_LEN    = 20;   // log2 of frame period in clk cycles
    localparam int POS_W        = 8;    // position width

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,    // after reset: let any pulse in progress finish
        ARMED    = 2'd1,    // input low, waiting for a rising edge
        HIGH     = 2'd2     // measuring the high time
    } dec_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with rise/fall edge detect
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (all flops clear to 0)
//   din   in   asynchronous input pin
//   level out  synchronized level (second sync stage)
//   rise  out  level went 0->1 this cycle
//   fall  out  level went 1->0 this cycle
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;
    assign fall  = ~s2 & prev;

endmodule

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - measures servo PWM high time and recovers position
//
// Purpose: receive-side counterpart of servo_controller. Measures each high
//          pulse, rounds it to whole position steps and reports the position,
//          or flags the pulse as out of range. Tracks loss of the pulse train.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   servo_in    in   asynchronous PWM input
//   position    out  last decoded position
//   valid       out  one-cycle strobe, position updated this cycle
//   pulse_err   out  one-cycle strobe, out-of-range pulse rejected
//   signal_lost out  level, no rising edge seen for TIMEOUT_TICKS cycles
module servo_pulse_decoder #(
    parameter int STEP_SHIFT    = servo_pkg::STEP_SHIFT,
    parameter int OFFSET_UNITS  = servo_pkg::OFFSET_UNITS,
    parameter int CNT_LEN       = servo_pkg::FRAME_LEN,
    parameter int TIMEOUT_TICKS = 2097152
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        servo_in,
    output logic [servo_pkg::POS_W-1:0] position,
    output logic                        valid,
    output logic                        pulse_err,
    output logic                        signal_lost
);

    import servo_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_TICKS);
    localparam logic [CNT_LEN:0] HALF_STEP = (CNT_LEN + 1)'(1) << (STEP_SHIFT - 1);

    logic             level;
    logic             rise;
    logic             fall;
    dec_state_t       state;
    logic [1:0]       settle;
    logic [CNT_LEN-1:0] width;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_LEN:0] rounded;
    logic [31:0]      units;
    logic             in_range;

    sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (servo_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Round to the nearest step; an extra bit keeps the carry of the half-step add.
    assign rounded  = {1'b0, width} + HALF_STEP;
    assign units    = 32'(rounded >> STEP_SHIFT);
    // A saturated counter means the true width is unknown, so it is never accepted.
    assign in_range = !(&width)
                   && (units >= 32'(OFFSET_UNITS))
                   && (units <= 32'(OFFSET_UNITS + 255));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_LOW;
            settle      <= 2'd0;
            width       <= '0;
            to_cnt      <= '0;
            position    <= '0;
            valid       <= 1'b0;
            pulse_err   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            valid     <= 1'b0;
            pulse_err <= 1'b0;

            // A rise in the same cycle as expiry wins, so the timeout is cancelled.
            if (rise) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (!rise && (to_cnt == TO_MAX)) begin
                signal_lost <= 1'b1;
            end

            case (state)
                WAIT_LOW: begin
                    // The sync flops come out of reset at 0, so a low level only
                    // counts once it has been seen for three edges; by then a pin
                    // that was high during reset has reached the second stage.
                    if (level) begin
                        settle <= 2'd0;
                    end else if (settle == 2'd2) begin
                        state <= ARMED;
                    end else begin
                        settle <= settle + 2'd1;
                    end
                end
                ARMED: begin
                    if (rise) begin
                        width <= CNT_LEN'(1);
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (in_range) begin
                            position    <= POS_W'(units - 32'(OFFSET_UNITS));
                            valid       <= 1'b1;
                            signal_lost <= 1'b0;
                        end else begin
                            pulse_err <= 1'b1;
                        end
                        state <= ARMED;
                    end else if (!(&width)) begin
                        width <= width + 1'b1;
                    end
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - directed self-checking bench for servo_pulse_decoder
module tb_servo_pulse_decoder;

    localparam int P_SHIFT = 2;
    localparam int P_OFF   = 5;
    localparam int P_CNT   = 11;
    localparam int P_TO    = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       servo_in = 1'b0;
    logic [7:0] position;
    logic       valid;
    logic       pulse_err;
    logic       signal_lost;

    int checks = 0;
    int failures = 0;

    int         n_valid = 0;
    int         n_err = 0;
    int         n_overlap = 0;
    logic [7:0] last_pos = 8'd0;
    logic       prev_strobe = 1'b0;

    always #5 clk = ~clk;

    servo_pulse_decoder #(
        .STEP_SHIFT    (P_SHIFT),
        .OFFSET_UNITS  (P_OFF),
        .CNT_LEN       (P_CNT),
        .TIMEOUT_TICKS (P_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .servo_in    (servo_in),
        .position    (position),
        .valid       (valid),
        .pulse_err   (pulse_err),
        .signal_lost (signal_lost)
    );

    always @(negedge clk) begin
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            if (valid) begin
                n_valid++;
                last_pos = position;
            end
            if (pulse_err) n_err++;
            if ((valid && pulse_err) || ((valid || pulse_err) && prev_strobe)) n_overlap++;
            prev_strobe = valid | pulse_err;
        end
    end

    task automatic clear_counts();
        n_valid = 0;
        n_err   = 0;
    endtask

    task automatic pulse(input int w);
        @(negedge clk);
        servo_in = 1'b1;
        repeat (w) @(negedge clk);
        servo_in = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        servo_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (position !== 8'd0) begin failures++; $display("FAIL reset_position: got %0d expected 0", position); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (pulse_err !== 1'b0) begin failures++; $display("FAIL reset_pulse_err: got %b expected 0", pulse_err); end
        checks++; if (signal_lost !== 1'b1) begin failures++; $display("FAIL reset_signal_lost: got %b expected 1", signal_lost); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_pos0_latency();
        clear_counts();
        @(negedge clk);
        servo_in = 1'b1;
        repeat (20) @(negedge clk);
        servo_in = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL latency_edge1_valid: got %b expected 0", valid); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL latency_edge2_valid: got %b expected 0", valid); end
        checks++; if (signal_lost !== 1'b1) begin failures++; $display("FAIL latency_lost_before: got %b expected 1", signal_lost); end
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL latency_edge3_valid: got %b expected 1", valid); end
        checks++; if (position !== 8'd0) begin failures++; $display("FAIL pos0_position: got %0d expected 0", position); end
        checks++; if (signal_lost !== 1'b0) begin failures++; $display("FAIL pos0_lost_cleared: got %b expected 0", signal_lost); end
        repeat (8) @(negedge clk);
        checks++; if (n_valid !== 1) begin failures++; $display("FAIL pos0_valid_count: got %0d expected 1", n_valid); end
    endtask

    task automatic test_decode_table();
        int         widths [10] = '{532, 18, 533, 530, 1040, 1044, 17, 16, 1, 2058};
        bit         oks    [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [7:0] poss   [10] = '{8'd128, 8'd0, 8'd128, 8'd128, 8'd255,
                                    8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        for (int i = 0; i < 10; i++) begin
            clear_counts();
            pulse(widths[i]);
            checks++; if (n_valid !== int'(oks[i])) begin failures++; $display("FAIL decode_valid_count w=%0d: got %0d expected %0d", widths[i], n_valid, oks[i]); end
            checks++; if (n_err !== int'(!oks[i])) begin failures++; $display("FAIL decode_err_count w=%0d: got %0d expected %0d", widths[i], n_err, !oks[i]); end
            checks++; if (position !== poss[i]) begin failures++; $display("FAIL decode_position w=%0d: got %0d expected %0d", widths[i], position, poss[i]); end
            checks++; if (signal_lost !== 1'b0) begin failures++; $display("FAIL decode_lost w=%0d: got %b expected 0", widths[i], signal_lost); end
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        pulse(532);
        repeat (2300) @(negedge clk);
        checks++; if (signal_lost !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b expected 0", signal_lost); end
        repeat (300) @(negedge clk);
        checks++; if (signal_lost !== 1'b1) begin failures++; $display("FAIL timeout_set: got %b expected 1", signal_lost); end
        checks++; if (position !== 8'd128) begin failures++; $display("FAIL timeout_position_hold: got %0d expected 128", position); end
        clear_counts();
        pulse(1);
        checks++; if (n_err !== 1) begin failures++; $display("FAIL lost_glitch_err: got %0d expected 1", n_err); end
        checks++; if (signal_lost !== 1'b1) begin failures++; $display("FAIL lost_not_cleared_by_err: got %b expected 1", signal_lost); end
        clear_counts();
        pulse(1040);
        checks++; if (n_valid !== 1) begin failures++; $display("FAIL recover_valid: got %0d expected 1", n_valid); end
        checks++; if (position !== 8'd255) begin failures++; $display("FAIL recover_position: got %0d expected 255", position); end
        checks++; if (signal_lost !== 1'b0) begin failures++; $display("FAIL recover_lost: got %b expected 0", signal_lost); end
    endtask

    task automatic test_reset_midpulse();
        clear_counts();
        @(negedge clk);
        servo_in = 1'b1;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (position !== 8'd0) begin failures++; $display("FAIL midreset_position: got %0d expected 0", position); end
        checks++; if (signal_lost !== 1'b1) begin failures++; $display("FAIL midreset_lost: got %b expected 1", signal_lost); end
        rst = 1'b0;
        repeat (300) @(negedge clk);
        servo_in = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (n_valid + n_err !== 0) begin failures++; $display("FAIL midreset_strobes: got %0d expected 0", n_valid + n_err); end
        clear_counts();
        pulse(532);
        checks++; if (n_valid !== 1) begin failures++; $display("FAIL after_reset_valid: got %0d expected 1", n_valid); end
        checks++; if (position !== 8'd128) begin failures++; $display("FAIL after_reset_position: got %0d expected 128", position); end
        checks++; if (signal_lost !== 1'b0) begin failures++; $display("FAIL after_reset_lost: got %b expected 0", signal_lost); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] frame_pos [3] = '{8'd0, 8'd64, 8'd200};
        for (int f = 0; f < 3; f++) begin
            int w;
            w = (int'(frame_pos[f]) + P_OFF) << P_SHIFT;
            clear_counts();
            @(negedge clk);
            servo_in = 1'b1;
            repeat (w) @(negedge clk);
            servo_in = 1'b0;
            repeat (1024 - w) @(negedge clk);
            checks++; if (n_valid !== 1) begin failures++; $display("FAIL frame%0d_valid_count: got %0d expected 1", f, n_valid); end
            checks++; if (last_pos !== frame_pos[f]) begin failures++; $display("FAIL frame%0d_position: got %0d expected %0d", f, last_pos, frame_pos[f]); end
            checks++; if (n_err !== 0) begin failures++; $display("FAIL frame%0d_err_count: got %0d expected 0", f, n_err); end
        end
    endtask

    initial begin
        test_reset();
        test_pos0_latency();
        test_decode_table();
        test_timeout();
        test_reset_midpulse();
        test_back_to_back();
        checks++; if (n_overlap !== 0) begin failures++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", n_overlap); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
